// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the serial BCD adder.
package bcd_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal carry correction.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   ci,
  output logic [BCD_DIGIT_W-1:0] s,
  output logic                   co
);

  logic [BCD_DIGIT_W:0] raw;
  logic [BCD_DIGIT_W:0] adj;

  // Non-BCD inputs fall through the same +6 correction; the result is defined but meaningless.
  assign raw = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, ci};
  assign adj = raw + 5'd6;
  assign co  = (raw > 5'(BCD_MAX_DIGIT));
  assign s   = co ? adj[BCD_DIGIT_W-1:0] : raw[BCD_DIGIT_W-1:0];

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD adder controller, one digit per clock through a shared digit adder.
// Optional operand digit checking (err port) is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BCD_DIGIT_W*NDIG-1:0] A,
  input  logic [BCD_DIGIT_W*NDIG-1:0] B,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BCD_DIGIT_W*NDIG-1:0] S,
  output logic                        cout,
  output logic                        busy
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                        err
`endif
);

  localparam int CW = $clog2(NDIG) + 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t                        state;
  logic [BCD_DIGIT_W*NDIG-1:0]   a_reg;
  logic [BCD_DIGIT_W*NDIG-1:0]   b_reg;
  logic [BCD_DIGIT_W*NDIG-1:0]   s_reg;
  logic [CW-1:0]                 cnt;
  logic                          carry;
  logic                          cout_reg;
  logic [BCD_DIGIT_W-1:0]        dig_a;
  logic [BCD_DIGIT_W-1:0]        dig_b;
  logic [BCD_DIGIT_W-1:0]        dig_s;
  logic                          dig_co;

  assign dig_a = a_reg[cnt*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign dig_b = b_reg[cnt*BCD_DIGIT_W +: BCD_DIGIT_W];

  bcd_digit_adder u_digit (
    .a  (dig_a),
    .b  (dig_b),
    .ci (carry),
    .s  (dig_s),
    .co (dig_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      s_reg    <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            carry    <= cin;
            cnt      <= '0;
            s_reg    <= '0;
            cout_reg <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          s_reg[cnt*BCD_DIGIT_W +: BCD_DIGIT_W] <= dig_s;
          carry <= dig_co;
          // Counter parks on the last digit rather than wrapping.
          if (cnt == LAST) begin
            cout_reg <= dig_co;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_in;
  logic err_reg;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (A[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'(BCD_MAX_DIGIT) ||
          B[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'(BCD_MAX_DIGIT))
        bad_in = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_reg <= 1'b0;
    else if (state == IDLE && in_valid)
      err_reg <= bad_in;
  end

  assign err = err_reg;
`endif

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign S         = s_reg;
  assign cout      = cout_reg;

endmodule

// File: doc/bcd_serial_adder_ctrl.md
BCD_SERIAL_ADDER_CTRL -- requirements
Module: bcd_serial_adder_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of BCD digits per operand (legal 1..16).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand request.
REQ-005 SHALL have port in_ready  output  1  controller can accept operands.
REQ-006 SHALL have port A  input  4*NDIG  first BCD operand, digit 0 in bits [3:0].
REQ-007 SHALL have port B  input  4*NDIG  second BCD operand.
REQ-008 SHALL have port cin  input  1  carry-in to digit 0.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port S  output  4*NDIG  BCD sum.
REQ-012 SHALL have port cout  output  1  decimal carry-out of top digit.
REQ-013 SHALL have port busy  output  1  high in RUN state.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE, busy=1 only in RUN, out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE with in_valid=1, register A, B, cin, clear digit counter and S register, go to RUN; A/B/cin changes after acceptance have no effect.
REQ-016 SHALL, in RUN, add exactly one digit per cycle, LSD first, via one shared digit adder: digit = A[i]+B[i]+carry, if >9 then add 6, write digit i of S, carry to next cycle.
REQ-017 SHALL go RUN->DONE after digit NDIG-1 is written; cout = final carry; accept-to-out_valid latency exactly NDIG+1 clk edges.
REQ-018 SHALL hold S, cout, out_valid stable in DONE until out_ready=1, then go to IDLE on that edge.
REQ-019 SHALL ignore in_valid in RUN and DONE (no queueing); a new accept is possible on the cycle after DONE exits.
REQ-020 SHALL ignore out_ready outside DONE.
REQ-021 SHALL size digit counter to $clog2(NDIG)+1 bits, never wrap past NDIG-1.
REQ-022 SHALL, for non-BCD digits (>9) without checking, produce the same digit-adder arithmetic result (defined, not meaningful).

Reset
REQ-023 SHALL on rst=1, asynchronously: state=IDLE, S=0, cout=0, out_valid=0, busy=0, in_ready=1 (after release), counter and carry=0.
REQ-024 SHALL abort any in-progress addition on reset with no result emitted.

Configuration
REQ-025 SHALL, with macro BCD_DIGIT_CHECK_EN defined, add port err  output  1: registered at accept, 1 if any A or B digit >9, presented with out_valid, cleared by reset and on next accept.
REQ-026 SHALL, without BCD_DIGIT_CHECK_EN, have no err port and no checking logic; all other behaviour identical.

Structure
REQ-027 SHALL place FSM state enum typedef, BCD_DIGIT_W=4 and BCD_MAX_DIGIT=9 constants in package bcd_pkg.
REQ-028 SHALL instantiate one combinational sub-module bcd_digit_adder (a[3:0], b[3:0], ci -> s[3:0], co) as the shared datapath.

Verification
REQ-029 NDIG=2: A=8'h07, B=8'h08, cin=0 -> S=8'h15, cout=0, out_valid 3 cycles after accept.
REQ-030 NDIG=2: A=8'h29, B=8'h17, cin=0 -> S=8'h46; A=8'h50, B=8'h50 -> S=8'h00, cout=1; A=8'h99, B=8'h99, cin=1 -> S=8'h99, cout=1.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> S/cout/out_valid stable, in_valid pulses ignored, in_ready=0.
REQ-032 Reset asserted mid-RUN (after digit 0) -> outputs zero immediately, in_ready=1 after release, no out_valid.
REQ-033 BCD_DIGIT_CHECK_EN, NDIG=2: A=8'h1A, B=8'h01 -> err=1 with out_valid; next A=8'h12 -> err=0.
REQ-034 Back-to-back: accept on first IDLE cycle after each DONE handshake, 10 random valid BCD pairs -> all sums match decimal reference.
